// File: rtl/timer_pkg.sv
// Shared types, seven-segment glyphs and preset conversion for the countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timerState_t;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int MAX_DIGITS = 6;

    // Converts a decimal preset into packed BCD, digit 0 in the low nibble
    function automatic logic [4*MAX_DIGITS-1:0] toBcd(input int unsigned value);
        int unsigned rest;
        logic [4*MAX_DIGITS-1:0] bcd;
        rest = value;
        bcd  = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(rest % 10);
            rest = rest / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// Control and display bundle between the game controller and the countdown timer.
interface game_countdown_timer_if #(
    parameter int DIGITS = 2
);
    logic                start;
    logic                pause;
    logic                auto_reload;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] count;
    logic [7*DIGITS-1:0] seg;
    logic                running;
    logic                flag;
    logic                expire;

    modport master (
        output start, pause, auto_reload, load_val,
        input  count, seg, running, flag, expire
    );

    modport slave (
        input  start, pause, auto_reload, load_val,
        output count, seg, running, flag, expire
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// Single-digit BCD to active-low seven-segment decoder; non-decimal codes blank the digit.
module bcd_to_seg7
    import timer_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup from nibble to glyph
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/game_countdown_timer.sv
// N-digit BCD countdown timer with prescaler, pause, auto-reload and expiry pulse.
module game_countdown_timer
    import timer_pkg::*;
#(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          TICK_HZ   = 1,
    parameter int          DIGITS    = 2,
    parameter int unsigned START_VAL = 30
)(
    input logic                   clock,
    input logic                   reset,
    game_countdown_timer_if.slave bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int W   = 4 * DIGITS;

    localparam logic [4*MAX_DIGITS-1:0] START_FULL = toBcd(START_VAL);
    localparam logic [W-1:0]            START_BCD  = START_FULL[W-1:0];
    localparam logic [W-1:0]            BCD_ONE    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]           PRE_LAST   = PW'(DIV - 1);

    timerState_t   state_q;
    logic [W-1:0]  count_q;
    logic [W-1:0]  lastLoad_q;
    logic [PW-1:0] prescaler_q;
    logic          running_q;
    logic          flag_q;
    logic          expire_q;

    logic [W-1:0]  clampedLoad_d;
    logic [W-1:0]  decremented_d;
    logic          borrow;
    logic [7*DIGITS-1:0] segAll;

    // Clamp the incoming preset per digit and form count-1 with borrow rippling upward
    always_comb begin
        clampedLoad_d = bus.load_val;
        decremented_d = count_q;
        borrow        = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_val[4*i +: 4] > 4'd9) begin
                clampedLoad_d[4*i +: 4] = 4'd9;
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    decremented_d[4*i +: 4] = 4'd9;
                end else begin
                    decremented_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Timer FSM: start loads from any state, RUN/PAUSE share the prescaler, expiry reloads or stops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= START_BCD;
            lastLoad_q  <= START_BCD;
            prescaler_q <= '0;
            running_q   <= 1'b0;
            flag_q      <= 1'b0;
            expire_q    <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            if (bus.start) begin
                prescaler_q <= '0;
                count_q     <= clampedLoad_d;
                lastLoad_q  <= clampedLoad_d;
                if (clampedLoad_d == '0) begin
                    state_q   <= DONE;
                    running_q <= 1'b0;
                    flag_q    <= 1'b1;
                    expire_q  <= 1'b1;
                end else begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                    flag_q    <= 1'b0;
                end
            end else begin
                case (state_q)
                    RUN, PAUSE: begin
                        if (bus.pause) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end else begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                            if (prescaler_q == PRE_LAST) begin
                                prescaler_q <= '0;
                                if (count_q == BCD_ONE) begin
                                    expire_q <= 1'b1;
                                    if (bus.auto_reload) begin
                                        count_q <= lastLoad_q;
                                    end else begin
                                        count_q   <= '0;
                                        state_q   <= DONE;
                                        running_q <= 1'b0;
                                        flag_q    <= 1'b1;
                                    end
                                end else begin
                                    count_q <= decremented_d;
                                end
                            end else begin
                                prescaler_q <= prescaler_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : gen_seg
        bcd_to_seg7 u_dec (
            .bcd_i (count_q[4*g +: 4]),
            .seg_o (segAll[7*g +: 7])
        );
    end

    assign bus.count   = count_q;
    assign bus.seg     = segAll;
    assign bus.running = running_q;
    assign bus.flag    = flag_q;
    assign bus.expire  = expire_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench: a decimal reference model predicts every post-edge output, a monitor compares.
module tb_game_countdown_timer;

    localparam int CLK_HZ    = 10;
    localparam int TICK_HZ   = 1;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int DIGITS    = 2;
    localparam int START_VAL = 30;

    typedef struct {
        int edgeTag;
        int value;
        bit running;
        bit flag;
        bit expire;
    } expect_t;

    logic clock = 1'b0;
    logic reset;
    int   edgeCount = 0;
    int   nCompared = 0;
    int   nMismatched = 0;
    expect_t expQ[$];

    int mValue, mLast, mPhase;
    bit mActive, mPaused, mDone, mExpire;

    logic [6:0] litMask [10];

    game_countdown_timer_if #(.DIGITS(DIGITS)) bus ();

    game_countdown_timer #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .DIGITS    (DIGITS),
        .START_VAL (START_VAL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock
    always #5 clock = ~clock;

    // Edge counter used to tag predictions with the edge they belong to
    always @(posedge clock) edgeCount <= edgeCount + 1;

    // Lit segments in {g,f,e,d,c,b,a} order; the display is the inverse
    initial begin
        litMask[0] = 7'b0111111;
        litMask[1] = 7'b0000110;
        litMask[2] = 7'b1011011;
        litMask[3] = 7'b1001111;
        litMask[4] = 7'b1100110;
        litMask[5] = 7'b1101101;
        litMask[6] = 7'b1111101;
        litMask[7] = 7'b0000111;
        litMask[8] = 7'b1111111;
        litMask[9] = 7'b1101111;
    end

    function automatic logic [7:0] bcdOf(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic modelReset();
        mValue  = START_VAL;
        mLast   = START_VAL;
        mPhase  = 0;
        mActive = 0;
        mPaused = 0;
        mDone   = 0;
        mExpire = 0;
    endtask

    // Decimal behaviour of one clock edge given the inputs sampled there
    task automatic modelEdge(input bit st, input bit pa, input bit au, input logic [7:0] lv);
        int tens, ones;
        mExpire = 0;
        if (st) begin
            tens    = (lv[7:4] > 9) ? 9 : int'(lv[7:4]);
            ones    = (lv[3:0] > 9) ? 9 : int'(lv[3:0]);
            mValue  = tens * 10 + ones;
            mLast   = mValue;
            mPhase  = 0;
            mPaused = 0;
            if (mValue == 0) begin
                mActive = 0;
                mDone   = 1;
                mExpire = 1;
            end else begin
                mActive = 1;
                mDone   = 0;
            end
        end else if (mActive) begin
            if (pa) begin
                mPaused = 1;
            end else begin
                mPaused = 0;
                mPhase++;
                if (mPhase == DIV) begin
                    mPhase = 0;
                    if (mValue == 1) begin
                        mExpire = 1;
                        if (au) begin
                            mValue = mLast;
                        end else begin
                            mValue  = 0;
                            mActive = 0;
                            mDone   = 1;
                        end
                    end else begin
                        mValue--;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input int expValue, input bit expRun,
                               input bit expFlag, input bit expExpire);
        logic [7:0]  expCount;
        logic [13:0] expSeg;
        expCount = bcdOf(expValue);
        expSeg   = ~{litMask[expValue / 10], litMask[expValue % 10]};
        nCompared++;
        if (bus.count !== expCount || bus.seg !== expSeg || bus.running !== expRun ||
            bus.flag !== expFlag || bus.expire !== expExpire) begin
            nMismatched++;
            $display("[TB] FAIL %s @edge %0d: got count=%h seg=%h run=%b flag=%b expire=%b, want count=%h seg=%h run=%b flag=%b expire=%b",
                     name, edgeCount, bus.count, bus.seg, bus.running, bus.flag, bus.expire,
                     expCount, expSeg, expRun, expFlag, expExpire);
        end
    endtask

    // Drive inputs for the coming edge and queue the model's prediction for it
    task automatic applyStimulus(input bit st, input bit pa, input bit au, input logic [7:0] lv);
        expect_t e;
        @(posedge clock);
        #1;
        bus.start       = st;
        bus.pause       = pa;
        bus.auto_reload = au;
        bus.load_val    = lv;
        modelEdge(st, pa, au, lv);
        e.edgeTag = edgeCount + 1;
        e.value   = mValue;
        e.running = mActive && !mPaused;
        e.flag    = mDone;
        e.expire  = mExpire;
        expQ.push_back(e);
    endtask

    task automatic idleCycles(input int n, input bit au);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, au, 8'h00);
    endtask

    // Asynchronous reset between edges, checked before the next edge arrives
    task automatic doAsyncReset();
        @(posedge clock);
        @(negedge clock);
        #2;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.auto_reload = 1'b0;
        bus.load_val    = 8'h00;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset", mValue, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare every prediction whose edge has already occurred
    initial begin
        expect_t e;
        forever begin
            @(negedge clock);
            while (expQ.size() > 0 && expQ[0].edgeTag <= edgeCount) begin
                e = expQ.pop_front();
                checkOutput("cycle", e.value, e.running, e.flag, e.expire);
            end
        end
    end

    initial begin
        bit   st, pa, au;
        int   pauseLeft;
        logic [7:0] lv;

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.auto_reload = 1'b0;
        bus.load_val    = 8'h00;
        modelReset();
        #3;
        checkOutput("reset_state", mValue, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Pause while idle is ignored
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        // 12 counts down through the borrow to expiry
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h12);
        idleCycles(130, 1'b0);

        // Pause for 37 cycles with the count at 03
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h05);
        idleCycles(20, 1'b0);
        for (int i = 0; i < 37; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        idleCycles(40, 1'b0);

        // Pause raised exactly on a tick edge
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h03);
        idleCycles(9, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        idleCycles(30, 1'b0);

        // Auto-reload 02,01,02,01... then let it stop
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h02);
        idleCycles(70, 1'b1);
        idleCycles(25, 1'b0);

        // Zero load, clamped load, and a start colliding with a tick
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        idleCycles(4, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA7);
        idleCycles(9, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h08);
        idleCycles(12, 1'b0);

        // Reset mid-run with the count at 07
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h09);
        idleCycles(25, 1'b0);
        doAsyncReset();
        idleCycles(15, 1'b0);

        // Randomised traffic
        pauseLeft = 0;
        au = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(0, 59) == 0);
            if (pauseLeft > 0) begin
                pa = 1'b1;
                pauseLeft--;
            end else if ($urandom_range(0, 49) == 0) begin
                pa = 1'b1;
                pauseLeft = $urandom_range(0, 29);
            end else begin
                pa = 1'b0;
            end
            if ($urandom_range(0, 199) == 0) au = ~au;
            lv[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            lv[3:0] = 4'($urandom_range(0, 15));
            applyStimulus(st, pa, au, lv);
        end

        @(posedge clock);
        @(negedge clock);
        #2;
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, want 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
